// File: rtl/xunit_f.sv
// SHA-256 compression unit: consumes one schedule word per cycle, runs 64 rounds,
// then folds the working variables into the chaining state H0..H7.
module xunit_f #(
  parameter int DELAY_W = 32,
  parameter int DATA_W  = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               run,
  output logic               done,
  input  logic [DATA_W-1:0]  in0,
  output logic [DATA_W-1:0]  out0,
  output logic [DATA_W-1:0]  out1,
  output logic [DATA_W-1:0]  out2,
  output logic [DATA_W-1:0]  out3,
  output logic [DATA_W-1:0]  out4,
  output logic [DATA_W-1:0]  out5,
  output logic [DATA_W-1:0]  out6,
  output logic [DATA_W-1:0]  out7,
  input  logic [DELAY_W-1:0] delay0,
  input  logic               init
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ROUND, S_FINAL} state_t;

  localparam logic [DATA_W-1:0] IV [8] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  localparam logic [DATA_W-1:0] K_ROM [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic logic [DATA_W-1:0] rotr(input logic [DATA_W-1:0] x, input int n);
    return (x >> n) | (x << (DATA_W - n));
  endfunction

  state_t              r_state;
  state_t              w_next;
  logic [DATA_W-1:0]   r_h   [8];
  logic [DATA_W-1:0]   r_v   [8];
  logic [DATA_W-1:0]   r_out [8];
  logic [5:0]          r_t;
  logic [DELAY_W-1:0]  r_delay;
  logic                r_done;

  logic                w_doRound;
  logic [DATA_W-1:0]   w_s0, w_s1, w_ch, w_maj, w_t1, w_t2;

  // WAIT with an exhausted delay counter behaves exactly like a round
  assign w_doRound = (r_state == S_ROUND) || ((r_state == S_WAIT) && (r_delay == '0));

  assign w_s1  = rotr(r_v[4], 6) ^ rotr(r_v[4], 11) ^ rotr(r_v[4], 25);
  assign w_ch  = (r_v[4] & r_v[5]) ^ (~r_v[4] & r_v[6]);
  assign w_t1  = r_v[7] + w_s1 + w_ch + K_ROM[r_t] + in0;
  assign w_s0  = rotr(r_v[0], 2) ^ rotr(r_v[0], 13) ^ rotr(r_v[0], 22);
  assign w_maj = (r_v[0] & r_v[1]) ^ (r_v[0] & r_v[2]) ^ (r_v[1] & r_v[2]);
  assign w_t2  = w_s0 + w_maj;

  always_ff @(posedge clk) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  w_next = S_IDLE;
      S_WAIT:  if (r_delay == '0) w_next = S_ROUND;
      S_ROUND: if (r_t == 6'd63) w_next = S_FINAL;
      S_FINAL: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
    if (run) w_next = S_WAIT;
  end

  // A run pulse restarts from any state; otherwise the state decides what moves
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 8; i++) begin
        r_h[i]   <= '0;
        r_v[i]   <= '0;
        r_out[i] <= '0;
      end
      r_t     <= '0;
      r_delay <= '0;
      r_done  <= 1'b1;
    end else if (run) begin
      r_done  <= 1'b0;
      r_delay <= delay0;
      r_t     <= '0;
      if (init) begin
        r_h <= IV;
        r_v <= IV;
      end else begin
        r_v <= r_h;
      end
    end else begin
      if ((r_state == S_WAIT) && (r_delay != '0))
        r_delay <= r_delay - DELAY_W'(1);
      if (w_doRound) begin
        r_v[7] <= r_v[6];
        r_v[6] <= r_v[5];
        r_v[5] <= r_v[4];
        r_v[4] <= r_v[3] + w_t1;
        r_v[3] <= r_v[2];
        r_v[2] <= r_v[1];
        r_v[1] <= r_v[0];
        r_v[0] <= w_t1 + w_t2;
        r_t    <= r_t + 6'd1;
      end
      if (r_state == S_FINAL) begin
        for (int i = 0; i < 8; i++) begin
          r_h[i]   <= r_h[i] + r_v[i];
          r_out[i] <= r_h[i] + r_v[i];
        end
        r_done <= 1'b1;
      end
    end
  end

  assign done = r_done;
  assign out0 = r_out[0];
  assign out1 = r_out[1];
  assign out2 = r_out[2];
  assign out3 = r_out[3];
  assign out4 = r_out[4];
  assign out5 = r_out[5];
  assign out6 = r_out[6];
  assign out7 = r_out[7];

endmodule

// File: tb/tb_xunit_f.sv
// Bench for xunit_f: known SHA-256 vectors plus random blocks, delays and restarts
// checked against a plain SHA-256 compression model.
module tb_xunit_f;

  logic        clk;
  logic        rst;
  logic        run;
  logic        done;
  logic [31:0] in0;
  logic [31:0] out0, out1, out2, out3, out4, out5, out6, out7;
  logic [31:0] delay0;
  logic        init;
  logic [255:0] outsVec;

  int checkCount = 0;
  int passCount  = 0;

  localparam logic [255:0] IV_VEC =
    256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
  localparam logic [255:0] ABC_DIGEST =
    256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] EMPTY_DIGEST =
    256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
  localparam logic [255:0] TWO_DIGEST =
    256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

  logic [31:0] kTab [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  logic [31:0]  msg  [16];
  logic [31:0]  wBuf [64];
  logic [255:0] modelH;

  xunit_f #(.DELAY_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst), .run(run), .done(done), .in0(in0),
    .out0(out0), .out1(out1), .out2(out2), .out3(out3),
    .out4(out4), .out5(out5), .out6(out6), .out7(out7),
    .delay0(delay0), .init(init)
  );

  assign outsVec = {out0, out1, out2, out3, out4, out5, out6, out7};

  always #5 clk = ~clk;

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // Message schedule expansion of the 16-word block in msg into wBuf
  task automatic loadSchedule();
    logic [31:0] s0, s1;
    for (int t = 0; t < 64; t++) begin
      if (t < 16) begin
        wBuf[t] = msg[t];
      end else begin
        s0 = rotr(wBuf[t-15], 7) ^ rotr(wBuf[t-15], 18) ^ (wBuf[t-15] >> 3);
        s1 = rotr(wBuf[t-2], 17) ^ rotr(wBuf[t-2], 19) ^ (wBuf[t-2] >> 10);
        wBuf[t] = wBuf[t-16] + s0 + wBuf[t-7] + s1;
      end
    end
  endtask

  function automatic logic [255:0] compress(input logic [255:0] hIn);
    logic [31:0]  v [8];
    logic [31:0]  s0, s1, ch, maj, tmp1, tmp2;
    logic [255:0] res;
    for (int i = 0; i < 8; i++) v[i] = hIn[255-32*i -: 32];
    for (int t = 0; t < 64; t++) begin
      s1   = rotr(v[4], 6) ^ rotr(v[4], 11) ^ rotr(v[4], 25);
      ch   = (v[4] & v[5]) ^ (~v[4] & v[6]);
      tmp1 = v[7] + s1 + ch + kTab[t] + wBuf[t];
      s0   = rotr(v[0], 2) ^ rotr(v[0], 13) ^ rotr(v[0], 22);
      maj  = (v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]);
      tmp2 = s0 + maj;
      for (int i = 7; i > 0; i--) v[i] = v[i-1];
      v[4] = v[4] + tmp1;
      v[0] = tmp1 + tmp2;
    end
    for (int i = 0; i < 8; i++) res[255-32*i -: 32] = hIn[255-32*i -: 32] + v[i];
    return res;
  endfunction

  task automatic checkOutput(input string tag, input logic [255:0] observed, input logic [255:0] expected);
    checkCount++;
    if (observed === expected) passCount++;
    else $display("[TB] FAIL %s: got %h, want %h", tag, observed, expected);
  endtask

  // Issues a run, streams wBuf after dly garbage cycles, and checks the digest;
  // abortAt >= 0 returns early mid-block so the caller can reset or restart
  task automatic applyStimulus(input bit ini, input int dly, input logic [31:0] garbage,
                               input int abortAt, input string tag);
    logic [255:0] expH;
    bit busyOk;
    @(negedge clk);
    run = 1'b1; init = ini; delay0 = dly; in0 = $urandom;
    if (ini) modelH = IV_VEC;
    expH = compress(modelH);
    busyOk = 1'b1;
    for (int j = 0; j < dly + 64; j++) begin
      @(negedge clk);
      run = 1'b0; init = 1'($urandom); delay0 = $urandom;
      if (done !== 1'b0) busyOk = 1'b0;
      if (j == abortAt) return;
      in0 = (j < dly) ? garbage : wBuf[j-dly];
    end
    @(negedge clk);
    if (done !== 1'b0) busyOk = 1'b0;
    in0 = $urandom;
    @(negedge clk);
    checkOutput({tag, "_busy"}, 256'(busyOk), 256'(1));
    checkOutput({tag, "_done"}, 256'(done), 256'(1));
    checkOutput({tag, "_digest"}, outsVec, expH);
    modelH = expH;
  endtask

  task automatic idleHold(input int cycles);
    bit holdOk;
    holdOk = 1'b1;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      in0 = $urandom; delay0 = $urandom; init = 1'($urandom);
      if (done !== 1'b1 || outsVec !== modelH) holdOk = 1'b0;
    end
    checkOutput("idle_hold", 256'(holdOk), 256'(1));
  endtask

  initial begin
    int dly, abortAt;
    bit ini;
    clk = 1'b0; rst = 1'b0; run = 1'b0; init = 1'b0; in0 = '0; delay0 = '0;
    modelH = '0;
    repeat (2) @(negedge clk);
    checkOutput("reset_done", 256'(done), 256'(1));
    checkOutput("reset_out", outsVec, 256'(0));
    rst = 1'b1;

    // Reset must win over a simultaneous run
    @(negedge clk);
    rst = 1'b0; run = 1'b1; init = 1'b1;
    @(negedge clk);
    rst = 1'b1; run = 1'b0;
    checkOutput("rst_over_run_done", 256'(done), 256'(1));
    checkOutput("rst_over_run_out", outsVec, 256'(0));

    msg = '{default: 32'h0};
    msg[0] = 32'h61626380; msg[15] = 32'h00000018;
    loadSchedule();
    applyStimulus(1'b1, 0, 32'hffffffff, -1, "abc");
    checkOutput("abc_vector", outsVec, ABC_DIGEST);
    idleHold(5);

    msg = '{default: 32'h0};
    msg[0] = 32'h80000000;
    loadSchedule();
    applyStimulus(1'b1, 0, 32'hffffffff, -1, "empty");
    checkOutput("empty_vector", outsVec, EMPTY_DIGEST);

    msg = '{32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
            32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
            32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
            32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
    loadSchedule();
    applyStimulus(1'b1, 0, 32'hffffffff, -1, "two_blk1");
    msg = '{default: 32'h0};
    msg[15] = 32'h000001c0;
    loadSchedule();
    applyStimulus(1'b0, 0, 32'hffffffff, -1, "two_blk2");
    checkOutput("two_vector", outsVec, TWO_DIGEST);

    msg = '{default: 32'h0};
    msg[0] = 32'h61626380; msg[15] = 32'h00000018;
    loadSchedule();
    applyStimulus(1'b1, 5, 32'hffffffff, -1, "abc_delay5");
    checkOutput("abc_delay5_vector", outsVec, ABC_DIGEST);

    // Reset in the middle of a block, then a clean rerun
    applyStimulus(1'b1, 0, 32'hffffffff, 30, "abc_abort");
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    modelH = '0;
    checkOutput("midreset_done", 256'(done), 256'(1));
    checkOutput("midreset_out", outsVec, 256'(0));
    applyStimulus(1'b1, 0, 32'hffffffff, -1, "abc_after_reset");
    checkOutput("abc_after_reset_vector", outsVec, ABC_DIGEST);

    // Restart while busy at round 20
    applyStimulus(1'b1, 0, 32'hffffffff, 20, "abc_first");
    applyStimulus(1'b1, 0, 32'hffffffff, -1, "abc_restart");
    checkOutput("abc_restart_vector", outsVec, ABC_DIGEST);

    for (int n = 0; n < 14; n++) begin
      for (int i = 0; i < 16; i++) msg[i] = $urandom;
      loadSchedule();
      ini = 1'($urandom_range(0, 1));
      dly = int'($urandom_range(0, 6));
      abortAt = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, dly + 60)) : -1;
      applyStimulus(ini, dly, $urandom, abortAt, "rand");
      if (abortAt < 0) idleHold(int'($urandom_range(1, 4)));
    end
    applyStimulus(1'b0, 2, $urandom, -1, "rand_tail");

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
